// File: rtl/mux4_sched_pkg.sv
// Shared types and defaults for the 4-way round-robin mux scheduler.
package mux4_sched_pkg;

    localparam int unsigned MAX_HOLD_DEFAULT = 4;
    localparam int unsigned N_REQ            = 4;
    localparam int unsigned IDX_W            = 2;
    localparam int unsigned HOLD_W           = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set req bit at or above ptr, modulo 4.
module rr_pick4
    import mux4_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan from the farthest offset down so the nearest candidate wins last.
    always_comb begin
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = ptr + IDX_W'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler owning a shared 4:1 mux with bounded tenure.
// Optional macro MUX4_SCHED_LOCK_EN adds a lock input that suppresses hold expiry.
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT,
    parameter int unsigned DATA_W   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   d,
`ifdef MUX4_SCHED_LOCK_EN
    input  logic                      lock,
`endif
    output logic [N_REQ-1:0]          grant,
    output logic [IDX_W-1:0]          sel,
    output logic                      valid,
    output logic [DATA_W-1:0]         y
);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic               at_max;
    logic               expire;
    logic               owner_req;

    rr_pick4 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign at_max    = (hold_cnt_q == HOLD_W'(MAX_HOLD));
    assign owner_req = req[sel_q];
`ifdef MUX4_SCHED_LOCK_EN
    assign expire    = at_max && !lock;
`else
    assign expire    = at_max;
`endif

    // Next-state: ptr already points past the owner, so the owner is searched last.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = GRANT;
                    sel_d      = pick_idx;
                    grant_d    = N_REQ'(1) << pick_idx;
                    valid_d    = 1'b1;
                    ptr_d      = pick_idx + IDX_W'(1);
                    hold_cnt_d = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (!owner_req || expire) begin
                    if (pick_found) begin
                        sel_d      = pick_idx;
                        grant_d    = N_REQ'(1) << pick_idx;
                        valid_d    = 1'b1;
                        ptr_d      = pick_idx + IDX_W'(1);
                        hold_cnt_d = HOLD_W'(1);
                    end else begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        valid_d    = 1'b0;
                        hold_cnt_d = '0;
                    end
                end else if (!at_max) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant = grant_q;
    assign sel   = sel_q;
    assign valid = valid_q;
    assign y     = valid_q ? d[32'(sel_q)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched with hand-computed expectations.
module tb_mux4_rr_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] d;
`ifdef MUX4_SCHED_LOCK_EN
    logic       lock;
`endif
    logic [3:0] grant;
    logic [1:0] sel;
    logic       valid;
    logic [0:0] y;

    int unsigned n_vec;
    int unsigned n_err;

    mux4_rr_sched #(.MAX_HOLD(4), .DATA_W(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .d     (d),
`ifdef MUX4_SCHED_LOCK_EN
        .lock  (lock),
`endif
        .grant (grant),
        .sel   (sel),
        .valid (valid),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [3:0] exp_h;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        d     = 4'b0000;
`ifdef MUX4_SCHED_LOCK_EN
        lock  = 1'b0;
`endif
        #3;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_sel",   32'(sel),   32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_y",     32'(y),     32'h0);
        chk("rst_hold",  32'(dut.hold_cnt_q), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from requester 2
        req = 4'b0100;
        d   = 4'b0100;
        tick();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_sel",   32'(sel),   32'h2);
        chk("single_valid", 32'(valid), 32'h1);
        chk("single_y",     32'(y),     32'h1);
        req = 4'b0000;
        tick();
        chk("idle_valid", 32'(valid), 32'h0);
        chk("idle_grant", 32'(grant), 32'h0);
        chk("idle_y",     32'(y),     32'h0);

        // Round robin, all requesting, from ptr=0
        do_reset();
        req = 4'b1111;
        d   = 4'b0101;
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 4; c++) begin
                tick();
                exp_g = 4'b0001 << (o % 4);
                exp_h = 4'(c + 1);
                chk($sformatf("rr_grant_o%0d_c%0d", o, c), 32'(grant), 32'(exp_g));
                chk($sformatf("rr_valid_o%0d_c%0d", o, c), 32'(valid), 32'h1);
                chk($sformatf("rr_hold_o%0d_c%0d", o, c),  32'(dut.hold_cnt_q), 32'(exp_h));
                chk($sformatf("rr_y_o%0d_c%0d", o, c),     32'(y), 32'(((o % 4) % 2) == 0));
            end
        end

        // Early release: owner 1 drops after 2 cycles while req[3] high
        req = 4'b1010;
        tick();
        chk("early_grant1", 32'(grant), 32'h2);
        tick();
        chk("early_hold2",  32'(dut.hold_cnt_q), 32'h2);
        req = 4'b1000;
        tick();
        chk("early_grant3", 32'(grant), 32'h8);
        chk("early_hold1",  32'(dut.hold_cnt_q), 32'h1);
        chk("early_valid",  32'(valid), 32'h1);

        // Sole requester 0: re-granted at each expiry
        req = 4'b0001;
        tick();
        chk("sole_grant0", 32'(grant), 32'h1);
        chk("sole_hold0",  32'(dut.hold_cnt_q), 32'h1);
        for (int c = 0; c < 10; c++) begin
            tick();
            exp_h = 4'(((c + 1) % 4) + 1);
            chk($sformatf("sole_grant_c%0d", c), 32'(grant), 32'h1);
            chk($sformatf("sole_valid_c%0d", c), 32'(valid), 32'h1);
            chk($sformatf("sole_hold_c%0d", c),  32'(dut.hold_cnt_q), 32'(exp_h));
        end

        // Async reset in the middle of owner 1's tenure
        req = 4'b0010;
        d   = 4'b0010;
        tick();
        chk("mid_grant1", 32'(grant), 32'h2);
        chk("mid_y1",     32'(y),     32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(grant), 32'h0);
        chk("mid_rst_valid", 32'(valid), 32'h0);
        chk("mid_rst_y",     32'(y),     32'h0);
        chk("mid_rst_sel",   32'(sel),   32'h0);
        chk("mid_rst_hold",  32'(dut.hold_cnt_q), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1010;
        tick();
        chk("post_rst_grant", 32'(grant), 32'h2);
        chk("post_rst_sel",   32'(sel),   32'h1);

`ifdef MUX4_SCHED_LOCK_EN
        // Lock extends owner 0 past MAX_HOLD; releasing lock hands over to 1
        do_reset();
        req  = 4'b0011;
        lock = 1'b1;
        for (int c = 0; c < 7; c++) begin
            tick();
            exp_h = (c < 3) ? 4'(c + 1) : 4'd4;
            chk($sformatf("lock_grant_c%0d", c), 32'(grant), 32'h1);
            chk($sformatf("lock_hold_c%0d", c),  32'(dut.hold_cnt_q), 32'(exp_h));
        end
        lock = 1'b0;
        tick();
        chk("unlock_grant", 32'(grant), 32'h2);
        chk("unlock_hold",  32'(dut.hold_cnt_q), 32'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
